psram_mem_tester: RTL and testbench

//  Parametrised PSRAM self-test engine; drives the psram controller's stb/we/addr/din port.

---
 rtl/psram_mem_tester.sv | 260 ++++++++++++++++++++++++++
 tb/tb_psram_mem_tester.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psram_mem_tester.sv
// psram_mem_tester: writes a generated pattern over an address window through the PSRAM
// controller port, reads it back and compares. Optional PSRAM_TESTER_LOOP_EN auto-repeats passing runs.
module psram_mem_tester #(
    parameter int unsigned DW          = 16,
    parameter int unsigned AW          = 24,
    parameter int unsigned WORD_COUNT  = 256,
    parameter int unsigned ADDR_STEP   = 1,
    parameter int unsigned ECW         = 8,
    parameter int unsigned TIMEOUT_CYC = 1023,
    parameter int unsigned LFSR_TAPS   = 'hB400
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          i_start,
    input  logic          i_abort,
    input  logic [1:0]    i_mode,
    input  logic [DW-1:0] i_seed,
    input  logic [AW-1:0] i_base_addr,
    output logic          o_stb,
    output logic          o_we,
    output logic [AW-1:0] o_addr,
    output logic [DW-1:0] o_din,
    input  logic          i_busy,
    input  logic [DW-1:0] i_dout,
    output logic          o_finished,
    output logic          o_pass,
    output logic          o_timeout,
    output logic [ECW-1:0] o_err_count,
    output logic [AW-1:0] o_first_err,
    output logic [3:0]    o_state
`ifdef PSRAM_TESTER_LOOP_EN
    ,
    output logic [15:0]   o_loop_count
`endif
);

    localparam int KW = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [KW-1:0] K_LAST = KW'(WORD_COUNT - 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [DW-1:0] TAPS   = DW'(LFSR_TAPS);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_WAIT_RDY = 4'd1,
        S_WR_REQ   = 4'd2,
        S_WR_ACK   = 4'd3,
        S_WR_WAIT  = 4'd4,
        S_RD_REQ   = 4'd5,
        S_RD_ACK   = 4'd6,
        S_RD_WAIT  = 4'd7,
        S_CHECK    = 4'd8,
        S_DONE     = 4'd9
    } state_t;

    state_t        state;
    logic [KW-1:0] k_q;
    logic [TW-1:0] tcnt;
    logic [1:0]    mode_q;
    logic [DW-1:0] seed_q;
    logic [AW-1:0] base_q;
    logic [AW-1:0] gen_addr;
    logic [DW-1:0] gen_walk;
    logic [DW-1:0] gen_lfsr;
    logic [DW-1:0] rd_data;

    logic [DW-1:0] gen_data;
    logic [DW-1:0] lfsr_next;
    logic [DW-1:0] walk_next;
    logic [AW-1:0] addr_next;
    logic          last_word;
    logic          mismatch;
    logic          waiting;
    logic          start_ok;

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    function automatic logic [DW-1:0] seed_fix(input logic [DW-1:0] s);
        return (s == '0) ? DW'(1) : s;
    endfunction

    assign o_state = state;

    // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
    always_comb begin
        gen_data = gen_lfsr;
        case (mode_q)
            2'd0:    gen_data = seed_q;
            2'd1:    gen_data = gen_walk;
            2'd2:    gen_data = DW'(gen_addr);
            default: gen_data = gen_lfsr;
        endcase
        lfsr_next = (gen_lfsr >> 1) ^ (gen_lfsr[0] ? TAPS : '0);
        walk_next = {gen_walk[DW-2:0], gen_walk[DW-1]};
        addr_next = gen_addr + AW'(ADDR_STEP);
        last_word = (k_q == K_LAST);
        mismatch  = (rd_data != gen_data);
        start_ok  = i_start && (state == S_IDLE || state == S_DONE);
        // Cycles in a handshake state that make no progress count toward the timeout.
        waiting   = ((state == S_WR_ACK || state == S_RD_ACK) && !i_busy) ||
                    ((state == S_WR_WAIT || state == S_RD_WAIT) && i_busy);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state       <= S_IDLE;
            k_q         <= '0;
            tcnt        <= '0;
            mode_q      <= '0;
            seed_q      <= '0;
            base_q      <= '0;
            gen_addr    <= '0;
            gen_walk    <= '0;
            gen_lfsr    <= '0;
            rd_data     <= '0;
            o_stb       <= 1'b0;
            o_we        <= 1'b0;
            o_addr      <= '0;
            o_din       <= '0;
            o_finished  <= 1'b0;
            o_pass      <= 1'b0;
            o_timeout   <= 1'b0;
            o_err_count <= '0;
            o_first_err <= '0;
`ifdef PSRAM_TESTER_LOOP_EN
            o_loop_count <= '0;
`endif
        end else if (i_abort) begin
            state      <= S_IDLE;
            o_stb      <= 1'b0;
            o_we       <= 1'b0;
            o_finished <= 1'b0;
        end else if (start_ok) begin
            state       <= S_WAIT_RDY;
            mode_q      <= i_mode;
            seed_q      <= i_seed;
            base_q      <= i_base_addr;
            gen_addr    <= i_base_addr;
            gen_walk    <= DW'(1);
            gen_lfsr    <= seed_fix(i_seed);
            k_q         <= '0;
            tcnt        <= '0;
            o_stb       <= 1'b0;
            o_we        <= 1'b0;
            o_finished  <= 1'b0;
            o_pass      <= 1'b0;
            o_timeout   <= 1'b0;
            o_err_count <= '0;
            o_first_err <= '0;
`ifdef PSRAM_TESTER_LOOP_EN
            o_loop_count <= '0;
`endif
        end else if (waiting && tcnt == T_LAST) begin
            state      <= S_DONE;
            o_timeout  <= 1'b1;
            o_stb      <= 1'b0;
            o_we       <= 1'b0;
            o_finished <= 1'b1;
            o_pass     <= 1'b0;
        end else begin
            case (state)
                S_WAIT_RDY: if (!i_busy) state <= S_WR_REQ;

                S_WR_REQ: begin
                    o_addr <= gen_addr;
                    o_din  <= gen_data;
                    o_stb  <= 1'b1;
                    o_we   <= 1'b1;
                    tcnt   <= '0;
                    state  <= S_WR_ACK;
                end

                S_WR_ACK, S_RD_ACK: begin
                    if (i_busy) begin
                        o_stb <= 1'b0;
                        o_we  <= 1'b0;
                        tcnt  <= '0;
                        state <= (state == S_WR_ACK) ? S_WR_WAIT : S_RD_WAIT;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end

                S_WR_WAIT: begin
                    if (!i_busy) begin
                        if (last_word) begin
                            // Regenerate the same sequence from the start for the read pass.
                            k_q      <= '0;
                            gen_addr <= base_q;
                            gen_walk <= DW'(1);
                            gen_lfsr <= seed_fix(seed_q);
                            state    <= S_RD_REQ;
                        end else begin
                            k_q      <= k_q + KW'(1);
                            gen_addr <= addr_next;
                            gen_walk <= walk_next;
                            gen_lfsr <= lfsr_next;
                            state    <= S_WR_REQ;
                        end
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end

                S_RD_REQ: begin
                    o_addr <= gen_addr;
                    o_stb  <= 1'b1;
                    o_we   <= 1'b0;
                    tcnt   <= '0;
                    state  <= S_RD_ACK;
                end

                S_RD_WAIT: begin
                    if (!i_busy) begin
                        rd_data <= i_dout;
                        state   <= S_CHECK;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end

                S_CHECK: begin
                    if (mismatch) begin
                        if (o_err_count != '1) o_err_count <= o_err_count + ECW'(1);
                        if (o_err_count == '0) o_first_err <= o_addr;
                    end
                    if (last_word) begin
                        state      <= S_DONE;
                        o_finished <= 1'b1;
                        o_pass     <= !mismatch && (o_err_count == '0);
                    end else begin
                        k_q      <= k_q + KW'(1);
                        gen_addr <= addr_next;
                        gen_walk <= walk_next;
                        gen_lfsr <= lfsr_next;
                        state    <= S_RD_REQ;
                    end
                end

`ifdef PSRAM_TESTER_LOOP_EN
                S_DONE: begin
                    if (o_pass) begin
                        state        <= S_WAIT_RDY;
                        o_finished   <= 1'b0;
                        o_pass       <= 1'b0;
                        o_loop_count <= o_loop_count + 16'd1;
                        k_q          <= '0;
                        gen_addr     <= base_q;
                        gen_walk     <= DW'(1);
                        gen_lfsr     <= seed_fix(seed_q);
                    end
                end
`endif

                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_psram_mem_tester.sv
// Self-checking bench for psram_mem_tester: randomized PSRAM controller model plus a
// spec-level reference for addresses, data patterns and error reporting.
module tb_psram_mem_tester;

    localparam int WC     = 4;
    localparam int SAT_WC = 300;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    always #5 clk_i = ~clk_i;

    logic        i_start, i_abort;
    logic [1:0]  i_mode;
    logic [15:0] i_seed;
    logic [23:0] i_base_addr;
    logic        stb, we, busy, finished, pass, timeout;
    logic [23:0] addr, first_err;
    logic [15:0] din, dout;
    logic [7:0]  err_count;
    logic [3:0]  state;

    logic        s_start, s_stb, s_we, s_busy, s_finished, s_pass, s_timeout;
    logic [23:0] s_addr, s_first;
    logic [15:0] s_din;
    logic [15:0] s_dout = 16'hEDCB;
    logic [7:0]  s_err;
    logic [3:0]  s_state;
`ifdef PSRAM_TESTER_LOOP_EN
    logic [15:0] loop_cnt, s_loop_cnt;
`endif

    psram_mem_tester #(.WORD_COUNT(WC)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .i_start(i_start), .i_abort(i_abort),
        .i_mode(i_mode), .i_seed(i_seed), .i_base_addr(i_base_addr),
        .o_stb(stb), .o_we(we), .o_addr(addr), .o_din(din),
        .i_busy(busy), .i_dout(dout),
        .o_finished(finished), .o_pass(pass), .o_timeout(timeout),
        .o_err_count(err_count), .o_first_err(first_err), .o_state(state)
`ifdef PSRAM_TESTER_LOOP_EN
        , .o_loop_count(loop_cnt)
`endif
    );

    psram_mem_tester #(.WORD_COUNT(SAT_WC)) dut_sat (
        .clk_i(clk_i), .rstn_i(rstn_i), .i_start(s_start), .i_abort(1'b0),
        .i_mode(2'd0), .i_seed(16'h1234), .i_base_addr(24'h000100),
        .o_stb(s_stb), .o_we(s_we), .o_addr(s_addr), .o_din(s_din),
        .i_busy(s_busy), .i_dout(s_dout),
        .o_finished(s_finished), .o_pass(s_pass), .o_timeout(s_timeout),
        .o_err_count(s_err), .o_first_err(s_first), .o_state(s_state)
`ifdef PSRAM_TESTER_LOOP_EN
        , .o_loop_count(s_loop_cnt)
`endif
    );

    // Controller model: random accept delay and latency, sparse memory, optional bit0 corruption.
    typedef struct {
        logic        we;
        logic [23:0] a;
        logic [15:0] d;
    } txn_t;

    logic [15:0] mem [logic [23:0]];
    txn_t        log_q[$];
    int          lat_cnt;
    bit          ack_en    = 1'b1;
    bit          flip_en   = 1'b0;
    logic [23:0] flip_addr = '0;

    always @(negedge clk_i) begin
        if (!rstn_i) begin
            busy    = 1'b0;
            dout    = '0;
            lat_cnt = 0;
        end else if (lat_cnt > 0) begin
            lat_cnt--;
            if (lat_cnt == 0) busy = 1'b0;
        end else if (stb && !busy && ack_en && ($urandom_range(0, 2) != 0)) begin
            busy    = 1'b1;
            lat_cnt = $urandom_range(1, 4);
            log_q.push_back(txn_t'{we, addr, din});
            if (we) mem[addr] = din;
            else begin
                dout = mem.exists(addr) ? mem[addr] : 16'h0000;
                if (flip_en && addr == flip_addr) dout[0] = ~dout[0];
            end
        end
    end

    // Second controller always returns a word that differs from the constant pattern.
    always @(negedge clk_i) begin
        if (!rstn_i)     s_busy = 1'b0;
        else if (s_busy) s_busy = 1'b0;
        else if (s_stb)  s_busy = 1'b1;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] exp_addr(input logic [23:0] b, input int k);
        return b + 24'(k);
    endfunction

    function automatic logic [15:0] exp_word(input logic [1:0] m, input logic [15:0] s,
                                             input logic [23:0] b, input int k);
        logic [15:0] l;
        case (m)
            2'd0: return s;
            2'd1: return 16'd1 << (k % 16);
            2'd2: return 16'(exp_addr(b, k));
            default: begin
                l = (s == 16'd0) ? 16'd1 : s;
                for (int i = 0; i < k; i++) l = l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
                return l;
            end
        endcase
    endfunction

    task automatic wait_done(input string name, input int budget);
        int cyc = 0;
        while (!finished && cyc < budget) begin
            @(negedge clk_i);
            cyc++;
        end
        check({name, "_done"}, 32'(finished), 32'd1);
    endtask

    task automatic pulse_start();
        @(negedge clk_i); i_start = 1'b1;
        @(negedge clk_i); i_start = 1'b0;
    endtask

    task automatic run_case(input string tag, input logic [1:0] m, input logic [15:0] s,
                            input logic [23:0] b, input bit fe, input logic [23:0] fa,
                            input bit e_pass, input int e_err, input logic [23:0] e_first);
        log_q.delete();
        mem.delete();
        flip_en = fe; flip_addr = fa;
        i_mode = m; i_seed = s; i_base_addr = b;
        pulse_start();
        wait_done(tag, 3000);
        check({tag, "_pass"},    32'(pass),      32'(e_pass));
        check({tag, "_errs"},    32'(err_count), 32'(e_err));
        check({tag, "_first"},   32'(first_err), 32'(e_first));
        check({tag, "_timeout"}, 32'(timeout),   32'd0);
        check({tag, "_state"},   32'(state),     32'd9);
        check({tag, "_ntxn"},    32'(log_q.size()), 32'(2 * WC));
        for (int i = 0; i < log_q.size() && i < 2 * WC; i++) begin
            check({tag, "_we"},   32'(log_q[i].we), 32'(i < WC));
            check({tag, "_addr"}, 32'(log_q[i].a),  32'(exp_addr(b, i % WC)));
            if (i < WC) check({tag, "_wdata"}, 32'(log_q[i].d), 32'(exp_word(m, s, b, i)));
        end
    endtask

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] seed;
        logic [23:0] base;
        bit          fe;
        logic [23:0] fa;
        bit          e_pass;
        int          e_err;
        logic [23:0] e_first;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int          cnt, guard, e_err;
        logic [23:0] b, fa, e_first, a;
        logic [1:0]  m;
        logic [15:0] s;
        bit          fe;

        tbl[0] = vec_t'{2'd2, 16'h0000, 24'hABCDEF, 1'b0, 24'h0,      1'b1, 0, 24'h0};
        tbl[1] = vec_t'{2'd2, 16'h0000, 24'hABCDEF, 1'b1, 24'hABCDF0, 1'b0, 1, 24'hABCDF0};
        tbl[2] = vec_t'{2'd0, 16'hA5A5, 24'hFFFFFE, 1'b0, 24'h0,      1'b1, 0, 24'h0};
        tbl[3] = vec_t'{2'd0, 16'hA5A5, 24'hFFFFFE, 1'b1, 24'h000001, 1'b0, 1, 24'h000001};
        tbl[4] = vec_t'{2'd1, 16'h0000, 24'h000100, 1'b1, 24'h000100, 1'b0, 1, 24'h000100};
        tbl[5] = vec_t'{2'd3, 16'h0000, 24'h123456, 1'b0, 24'h0,      1'b1, 0, 24'h0};
        tbl[6] = vec_t'{2'd3, 16'hACE1, 24'h200000, 1'b1, 24'h200003, 1'b0, 1, 24'h200003};
        tbl[7] = vec_t'{2'd1, 16'h0000, 24'h300000, 1'b1, 24'h400000, 1'b1, 0, 24'h0};

        rstn_i = 1'b0; i_start = 1'b0; i_abort = 1'b0; s_start = 1'b0;
        i_mode = '0; i_seed = '0; i_base_addr = '0;
        repeat (3) @(negedge clk_i);
        check("rst_state",    32'(state),     32'd0);
        check("rst_stb",      32'(stb),       32'd0);
        check("rst_we",       32'(we),        32'd0);
        check("rst_addr",     32'(addr),      32'd0);
        check("rst_finished", 32'(finished),  32'd0);
        check("rst_pass",     32'(pass),      32'd0);
        check("rst_errs",     32'(err_count), 32'd0);
        rstn_i = 1'b1;
        repeat (2) @(negedge clk_i);

        for (int i = 0; i < 8; i++)
            run_case($sformatf("vec%0d", i), tbl[i].mode, tbl[i].seed, tbl[i].base, tbl[i].fe,
                     tbl[i].fa, tbl[i].e_pass, tbl[i].e_err, tbl[i].e_first);

        for (int r = 0; r < 16; r++) begin
            m  = 2'($urandom_range(0, 3));
            s  = 16'($urandom);
            b  = 24'($urandom);
            fe = 1'($urandom_range(0, 1));
            fa = b + 24'($urandom_range(0, 5));
            e_err = 0; e_first = '0;
            for (int k = 0; k < WC; k++) begin
                a = exp_addr(b, k);
                if (fe && a == fa) begin
                    if (e_err == 0) e_first = a;
                    e_err++;
                end
            end
            run_case($sformatf("rnd%0d", r), m, s, b, fe, fa, e_err == 0, e_err, e_first);
        end

        // Controller never acknowledges: the first write strobe must time out.
        ack_en = 1'b0;
        i_mode = 2'd0; i_seed = 16'h5555; i_base_addr = 24'h000010;
        pulse_start();
        cnt = 0; guard = 0;
        while (!finished && guard < 3000) begin
            @(negedge clk_i);
            if (state == 4'd3) cnt++;
            guard++;
        end
        check("tmo_done",     32'(finished), 32'd1);
        check("tmo_ack_cyc",  32'(cnt),      32'd1023);
        check("tmo_flag",     32'(timeout),  32'd1);
        check("tmo_pass",     32'(pass),     32'd0);
        check("tmo_stb",      32'(stb),      32'd0);
        check("tmo_state",    32'(state),    32'd9);
        ack_en = 1'b1;
        run_case("after_tmo", 2'd2, 16'h0, 24'h000040, 1'b0, 24'h0, 1'b1, 0, 24'h0);

        // Abort while a read is in flight, then abort beating a simultaneous start.
        log_q.delete(); mem.delete(); flip_en = 1'b0;
        i_mode = 2'd1; i_base_addr = 24'h000500;
        pulse_start();
        guard = 0;
        while (state != 4'd7 && guard < 3000) begin
            @(negedge clk_i);
            guard++;
        end
        check("abort_reach_rd_wait", 32'(state), 32'd7);
        i_abort = 1'b1;
        @(negedge clk_i);
        check("abort_state", 32'(state), 32'd0);
        check("abort_stb",   32'(stb),   32'd0);
        check("abort_we",    32'(we),    32'd0);
        i_start = 1'b1;
        @(negedge clk_i);
        check("abort_prio_state", 32'(state), 32'd0);
        i_start = 1'b0; i_abort = 1'b0;
        guard = 0;
        while (busy && guard < 100) begin
            @(negedge clk_i);
            guard++;
        end
        check("abort_ctrl_idle", 32'(busy), 32'd0);
        run_case("after_abort", 2'd3, 16'hBEEF, 24'h000600, 1'b1, 24'h000602, 1'b0, 1, 24'h000602);

        // Every read mismatches over 300 words: the counter must stop at 255.
        @(negedge clk_i); s_start = 1'b1;
        @(negedge clk_i); s_start = 1'b0;
        guard = 0;
        while (!s_finished && guard < 20000) begin
            @(negedge clk_i);
            guard++;
        end
        check("sat_done",    32'(s_finished), 32'd1);
        check("sat_errs",    32'(s_err),      32'd255);
        check("sat_first",   32'(s_first),    32'h000100);
        check("sat_pass",    32'(s_pass),     32'd0);
        check("sat_timeout", 32'(s_timeout),  32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
